// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the HD44780-style LCD command sequencer.
//   state_t      - sequencer FSM states
//   INIT_LEN     - number of power-on init writes
//   INIT_ROM     - power-on init bytes (all written with rs=0)
//   is_slow_cmd  - true for clear-display / return-home, which need the long settle
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_LOAD     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SETUP    = 3'd3,
    ST_EN_HI    = 3'd4,
    ST_HOLD     = 3'd5,
    ST_SETTLE   = 3'd6
  } state_t;

  localparam int INIT_LEN = 6;

  // 8-bit bus / 2 lines, repeated three times for a reliable function set,
  // then display on, clear, entry mode increment.
  localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{
    8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
  };

  // Clear (0x01) and return-home (0x02/0x03) are the only instructions whose
  // upper six bits are zero; both take ~1.6 ms inside the controller.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Shared down-counter used for every timed sequencer state.
//   clk       in   clock
//   rst       in   asynchronous active-high reset (count -> 0)
//   load      in   load strobe, takes priority over counting
//   load_val  in   value to load (N-1 for an N-cycle state)
//   zero      out  count has reached 0
module lcd_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Write-only HD44780-style LCD sequencer. Runs the power-on init sequence after
// reset, then accepts one instruction/data byte per valid/ready handshake and
// produces the full bus cycle: setup, E pulse, hold, settle.
//   clk_clk      in   system clock
//   reset_reset  in   asynchronous active-high reset
//   req_valid    in   requester presents a byte
//   req_rs       in   0 = instruction, 1 = character data
//   req_data     in   byte to write
//   req_ready    out  high only while idle
//   init_done    out  init sequence finished, sticky until reset
//   lcd_data     out  D7..D0
//   lcd_en       out  E strobe
//   lcd_rs       out  register select
//   lcd_rw       out  always 0
//
// state       | meaning
// PWR_WAIT    | power-up delay before the first init write
// LOAD        | pick next init byte, or finish init
// IDLE        | ready for a requester byte
// SETUP       | rs/data stable, E low
// EN_HI       | E high
// HOLD        | E low, rs/data held
// SETTLE      | wait for the LCD to execute the write
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int T_PWR = 750000,
  parameter int T_SU  = 4,
  parameter int T_EN  = 25,
  parameter int T_H   = 4,
  parameter int T_CMD = 2500,
  parameter int T_CLR = 82000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  localparam int M1    = (T_PWR > T_SU)  ? T_PWR : T_SU;
  localparam int M2    = (T_EN  > T_H)   ? T_EN  : T_H;
  localparam int M3    = (T_CMD > T_CLR) ? T_CMD : T_CLR;
  localparam int M12   = (M1 > M2)   ? M1 : M2;
  localparam int T_MAX = (M12 > M3)  ? M12 : M3;
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LD_PWR = CW'(T_PWR - 1);
  localparam logic [CW-1:0] LD_SU  = CW'(T_SU  - 1);
  localparam logic [CW-1:0] LD_EN  = CW'(T_EN  - 1);
  localparam logic [CW-1:0] LD_H   = CW'(T_H   - 1);
  localparam logic [CW-1:0] LD_CMD = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LD_CLR = CW'(T_CLR - 1);

  state_t        state, state_next;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic          latch_rom, latch_req, set_done, idx_inc;
  logic [2:0]    init_idx;
  // The counter comes out of reset at 0; the first PWR_WAIT cycle arms it.
  logic          pwr_armed;

  lcd_delay_counter #(.W(CW)) u_delay (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= ST_PWR_WAIT;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    latch_rom  = 1'b0;
    latch_req  = 1'b0;
    set_done   = 1'b0;
    idx_inc    = 1'b0;
    case (state)
      ST_PWR_WAIT: begin
        if (!pwr_armed) begin
          cnt_load = 1'b1;
          cnt_val  = LD_PWR;
        end else if (cnt_zero) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (init_idx < 3'(INIT_LEN)) begin
          latch_rom  = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = LD_SU;
          state_next = ST_SETUP;
        end else begin
          set_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          latch_req  = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = LD_SU;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load   = 1'b1;
          cnt_val    = LD_EN;
          state_next = ST_EN_HI;
        end
      end
      ST_EN_HI: begin
        if (cnt_zero) begin
          cnt_load   = 1'b1;
          cnt_val    = LD_H;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load   = 1'b1;
          cnt_val    = is_slow_cmd(lcd_rs, lcd_data) ? LD_CLR : LD_CMD;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          if (!init_done) begin
            idx_inc    = 1'b1;
            state_next = ST_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_PWR_WAIT;
    endcase
  end

  // rs/data only change on the transition into SETUP, so they are stable
  // through EN_HI, HOLD and SETTLE. E is registered to keep the pin glitch-free.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      init_done <= 1'b0;
      init_idx  <= 3'd0;
      pwr_armed <= 1'b0;
    end else begin
      pwr_armed <= 1'b1;
      if (latch_rom) begin
        lcd_data <= INIT_ROM[init_idx];
        lcd_rs   <= 1'b0;
      end else if (latch_req) begin
        lcd_data <= req_data;
        lcd_rs   <= req_rs;
      end
      lcd_en <= (state_next == ST_EN_HI);
      if (set_done) init_done <= 1'b1;
      if (idx_inc)  init_idx  <= init_idx + 3'd1;
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
module tb_lcd_cmd_sequencer;

  localparam int T_PWR = 20;
  localparam int T_SU  = 2;
  localparam int T_EN  = 4;
  localparam int T_H   = 2;
  localparam int T_CMD = 10;
  localparam int T_CLR = 40;
  // handshake cycle -> ready high again, excluding settle
  localparam int BUS   = 1 + T_SU + T_EN + T_H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_cmd_sequencer #(
    .T_PWR(T_PWR), .T_SU(T_SU), .T_EN(T_EN), .T_H(T_H), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .req_valid   (req_valid),
    .req_rs      (req_rs),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .init_done   (init_done),
    .lcd_data    (lcd_data),
    .lcd_en      (lcd_en),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  int         rise_cyc[$];
  int         pulses = 0;
  int         en_start = 0;
  logic       prev_en = 1'b0;
  logic [8:0] cap = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bus monitor: pops the scoreboard on each E rising edge.
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      pulses++;
      rise_cyc.push_back(cyc);
      en_start = cyc;
      cap = {lcd_rs, lcd_data};
      if (exp_q.size() == 0) chk("unexpected_pulse", {23'd0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
      else chk("write_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_q.pop_front()});
    end else if (lcd_en && prev_en) begin
      chk("data_stable_en_hi", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
    end else if (!lcd_en && prev_en && !rst) begin
      chk("en_width", cyc - en_start, T_EN);
    end
    if (lcd_en) chk("rw_zero", {31'd0, lcd_rw}, 32'd0);
    prev_en = lcd_en;
  end

  task automatic wait_ready(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) chk("init_done_timeout", 0, 1);
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic check_init(input int rel, input int done, input int p0);
    chk("init_pulses", pulses - p0, 6);
    chk("init_queue_empty", exp_q.size(), 0);
    if (rise_cyc.size() >= 6) begin
      chk("pwr_wait_quiet", (rise_cyc[0] - rel) > T_PWR, 1);
      for (int i = 0; i < 5; i++)
        chk("init_gap", rise_cyc[i+1] - rise_cyc[i], BUS + ((i == 4) ? T_CLR : T_CMD));
      chk("init_done_time", done - rise_cyc[5], T_EN + T_H + T_CMD + 1);
    end else begin
      chk("init_rise_count", rise_cyc.size(), 6);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int hs);
    int r;
    wait_ready(500, r);
    req_valid = 1'b1;
    req_rs = rs;
    req_data = d;
    exp_q.push_back({rs, d});
    hs = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data = 8'hA5;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, done, hs, hs2, rdy, rdy2, p0, r;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_en", {31'd0, lcd_en}, 0);
    chk("rst_data_rs", {23'd0, lcd_rs, lcd_data}, 0);
    chk("rst_init_done", {31'd0, init_done}, 0);
    chk("rst_ready", {31'd0, req_ready}, 0);
    chk("rst_rw", {31'd0, lcd_rw}, 0);

    // power-on init, with a requester already asserting valid
    push_init();
    rise_cyc.delete();
    p0 = pulses;
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h77;
    rst = 1'b0;
    rel = cyc;
    wait_done(3000, done);
    req_valid = 1'b0;
    check_init(rel, done, p0);
    repeat (30) @(negedge clk);
    chk("no_pulse_after_init", pulses - p0, 6);
    chk("idle_ready", {31'd0, req_ready}, 1);

    // single data write
    rise_cyc.delete();
    p0 = pulses;
    send(1'b1, 8'h41, hs);
    wait_ready(500, rdy);
    chk("en_rise_delay", (rise_cyc.size() > 0) ? rise_cyc[0] - hs : -1, 1 + T_SU);
    chk("ready_low_cycles", rdy - hs - 1, BUS + T_CMD - 1);
    chk("single_pulse", pulses - p0, 1);

    // back-to-back with valid held high
    p0 = pulses;
    wait_ready(500, r);
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h48;
    exp_q.push_back({1'b1, 8'h48});
    exp_q.push_back({1'b1, 8'h49});
    hs = cyc;
    @(posedge clk);
    #1;
    req_data = 8'h49;
    wait_ready(500, rdy);
    hs2 = rdy;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_ready(500, rdy2);
    chk("b2b_first_busy", rdy - hs, BUS + T_CMD);
    chk("b2b_second_busy", rdy2 - hs2, BUS + T_CMD);
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // home instruction vs. the same byte as character data
    send(1'b0, 8'h02, hs);
    wait_ready(500, rdy);
    chk("home_settle", rdy - hs, BUS + T_CLR);
    send(1'b1, 8'h02, hs);
    wait_ready(500, rdy);
    chk("data02_settle", rdy - hs, BUS + T_CMD);
    send(1'b0, 8'h80, hs);
    wait_ready(500, rdy);
    chk("ddram_settle", rdy - hs, BUS + T_CMD);

    // reset during EN_HI, then full re-init with valid held during init
    send(1'b1, 8'h55, hs);
    r = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lcd_en) begin
        r = 1;
        break;
      end
    end
    chk("reached_en_hi", r, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", {31'd0, lcd_en}, 0);
    chk("mid_rst_init_done", {31'd0, init_done}, 0);
    chk("mid_rst_rw", {31'd0, lcd_rw}, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_queue_empty", exp_q.size(), 0);
    push_init();
    rise_cyc.delete();
    p0 = pulses;
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
    rst = 1'b0;
    rel = cyc;
    wait_done(3000, done);
    req_valid = 1'b0;
    check_init(rel, done, p0);
    repeat (30) @(negedge clk);
    chk("reinit_no_extra", pulses - p0, 6);
    chk("reinit_ready", {31'd0, req_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
